// File: rtl/wb_arbiter.sv
// wb_arbiter -- write-back arbiter for the single register-file write port.
//
// Two result sources share the WE/WA/WD port:
//   * ALU path: single-cycle and never stalled. It always wins the port.
//   * Multi-cycle path (MDU/load): valid/ready handshake into an in-order
//     FIFO. The FIFO drains into cycles where the ALU does not write.
// Hazard-query ports report registers whose writes are still pending,
// either in the output register or in the FIFO.
//
// Optional build macro:
//   WB_FWD_EN  When defined, q_fd1/q_fd2 return the youngest pending data
//              for the queried register. When undefined, both are tied to 0.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   alu_valid/wa/wd       ALU result (always accepted)
//   mdu_valid/ready/wa/wd multi-cycle result handshake
//   WE, WA, WD            registered register-file write port
//   q_ra1/2, q_hit1/2     hazard query address / pending-write hit
//   q_fd1/2               forwarded data (WB_FWD_EN only, else 0)
//   pend_cnt              FIFO occupancy
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_wa,
   input  logic [DW-1:0]            alu_wd,
   input  logic                     mdu_valid,
   output logic                     mdu_ready,
   input  logic [AW-1:0]            mdu_wa,
   input  logic [DW-1:0]            mdu_wd,
   output logic                     WE,
   output logic [AW-1:0]            WA,
   output logic [DW-1:0]            WD,
   input  logic [AW-1:0]            q_ra1,
   input  logic [AW-1:0]            q_ra2,
   output logic                     q_hit1,
   output logic                     q_hit2,
   output logic [DW-1:0]            q_fd1,
   output logic [DW-1:0]            q_fd2,
   output logic [$clog2(DEPTH):0]   pend_cnt
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] fifo_wa [DEPTH];
   logic [DW-1:0] fifo_wd [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push;
   logic          pop;

   // Acceptance looks at occupancy only: a full FIFO refuses even when it
   // pops in the same cycle, which keeps mdu_ready free of alu_valid.
   assign mdu_ready = !rst && (pend_cnt != (PW+1)'(DEPTH));

   // A result for x0 completes its handshake but is dropped here.
   assign push = mdu_valid && mdu_ready && (mdu_wa != '0);
   assign pop  = !alu_valid && (pend_cnt != '0);

   // NOTE: the FIFO storage has no reset; occupancy and pointers alone
   // decide which slots are meaningful, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wa[wr_ptr] <= mdu_wa;
         fifo_wd[wr_ptr] <= mdu_wd;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         pend_cnt <= '0;
         WE       <= 1'b0;
         WA       <= '0;
         WD       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         pend_cnt <= pend_cnt + (PW+1)'(push) - (PW+1)'(pop);

         if (alu_valid) begin
            WE <= (alu_wa != '0);
            WA <= alu_wa;
            WD <= alu_wd;
         end else if (pop) begin
            WE <= 1'b1;
            WA <= fifo_wa[rd_ptr];
            WD <= fifo_wd[rd_ptr];
         end else begin
            WE <= 1'b0;
         end
      end
   end

   // Hazard query. Slots are walked from oldest to youngest, so with
   // forwarding enabled the last match found is the youngest pending write.
   logic [AW-1:0] ra  [2];
   logic          hit [2];
   logic [DW-1:0] fd  [2];

   assign ra[0] = q_ra1;
   assign ra[1] = q_ra2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         hit[p] = WE && (WA == ra[p]);
         fd[p]  = (WE && (WA == ra[p])) ? WD : '0;
         for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = rd_ptr + PW'(k);
            if (((PW+1)'(k) < pend_cnt) && (fifo_wa[idx] == ra[p])) begin
               hit[p] = 1'b1;
               fd[p]  = fifo_wd[idx];
            end
         end
         if (ra[p] == '0) begin
            hit[p] = 1'b0;
            fd[p]  = '0;
         end
      end
   end

   assign q_hit1 = hit[0];
   assign q_hit2 = hit[1];

`ifdef WB_FWD_EN
   assign q_fd1 = fd[0];
   assign q_fd2 = fd[1];
`else
   assign q_fd1 = '0;
   assign q_fd2 = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- self-checking bench for wb_arbiter (DEPTH=4, AW=5, DW=32).
// A queue-based reference model tracks the pending results and the write
// port; every cycle all DUT outputs are compared against it on the falling
// edge. Directed scenarios are followed by randomized traffic.
module tb_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [AW-1:0] alu_wa;
   logic [DW-1:0] alu_wd;
   logic          mdu_valid;
   logic          mdu_ready;
   logic [AW-1:0] mdu_wa;
   logic [DW-1:0] mdu_wd;
   logic          WE;
   logic [AW-1:0] WA;
   logic [DW-1:0] WD;
   logic [AW-1:0] q_ra1;
   logic [AW-1:0] q_ra2;
   logic          q_hit1;
   logic          q_hit2;
   logic [DW-1:0] q_fd1;
   logic [DW-1:0] q_fd2;
   logic [$clog2(DEPTH):0] pend_cnt;

   wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
      .WE(WE), .WA(WA), .WD(WD),
      .q_ra1(q_ra1), .q_ra2(q_ra2), .q_hit1(q_hit1), .q_hit2(q_hit2),
      .q_fd1(q_fd1), .q_fd2(q_fd2), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: pending results in acceptance order plus write port.
   typedef struct {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          mq[$];
   logic          m_we = 1'b0;
   logic [AW-1:0] m_wa = '0;
   logic [DW-1:0] m_wd = '0;
   bit            m_acc;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_hit(input logic [AW-1:0] ra);
      if (ra == '0) return 1'b0;
      if (m_we && m_wa == ra) return 1'b1;
      foreach (mq[i]) if (mq[i].wa == ra) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_fd(input logic [AW-1:0] ra);
`ifdef WB_FWD_EN
      if (ra == '0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].wa == ra) return mq[i].wd;
      if (m_we && m_wa == ra) return m_wd;
      return '0;
`else
      return (ra == '0) ? '0 : '0;
`endif
   endfunction

   // One clock: check every output at the falling edge, then advance the
   // model at the rising edge using the inputs the DUT sampled.
   task automatic cycle();
      bit rdy;
      ent_t e;
      @(negedge clk);
      rdy = !rst && (mq.size() != DEPTH);
      check("mdu_ready", mdu_ready, rdy);
      check("pend_cnt", pend_cnt, mq.size());
      check("WE", WE, m_we);
      check("WA", WA, m_wa);
      check("WD", WD, m_wd);
      check("q_hit1", q_hit1, exp_hit(q_ra1));
      check("q_hit2", q_hit2, exp_hit(q_ra2));
      check("q_fd1", q_fd1, exp_fd(q_ra1));
      check("q_fd2", q_fd2, exp_fd(q_ra2));
      @(posedge clk);
      m_acc = !rst && mdu_valid && rdy;
      if (rst) begin
         mq.delete();
         m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else begin
         if (alu_valid) begin
            m_we = (alu_wa != '0); m_wa = alu_wa; m_wd = alu_wd;
         end else if (mq.size() != 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wa = e.wa; m_wd = e.wd;
         end else begin
            m_we = 1'b0;
         end
         if (m_acc && mdu_wa != '0) begin
            e.wa = mdu_wa; e.wd = mdu_wd;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int id;
      rst = 1'b1; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
      mdu_valid = 1'b1; mdu_wa = 5'd9; mdu_wd = 32'h99;
      q_ra1 = '0; q_ra2 = '0;
      @(posedge clk); #1;

      // Reset held with mdu_valid high: nothing accepted, nothing written.
      cycle(); cycle();
      rst = 1'b0; mdu_valid = 1'b0;
      cycle();
      check("rst_we", WE, 1'b0);
      check("rst_pend", pend_cnt, 0);
      check("rst_wa", WA, 0);

      // ALU path, one-cycle latency; x0 destination suppresses WE.
      alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
      cycle();
      check("alu_we", WE, 1'b1);
      check("alu_wa", WA, 5);
      check("alu_wd", WD, 32'hDEADBEEF);
      alu_wa = '0; alu_wd = 32'h1234;
      cycle();
      check("alu_x0_we", WE, 1'b0);
      alu_valid = 1'b0;
      cycle();

      // Fill under continuous ALU traffic, then drain in order.
      alu_valid = 1'b1; alu_wa = 5'd20;
      id = 1; mdu_valid = 1'b1; mdu_wa = 5'(id); mdu_wd = 32'(100 + id);
      for (int i = 0; i < 6; i++) begin
         alu_wd = $urandom;
         cycle();
         if (m_acc && id < 5) begin
            id++; mdu_wa = 5'(id); mdu_wd = 32'(100 + id);
         end
      end
      check("full_pend", pend_cnt, 4);
      check("full_ready", mdu_ready, 1'b0);
      alu_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cycle();
         if (m_acc) mdu_valid = 1'b0;
         check("drain_we", WE, 1'b1);
         check("drain_wa", WA, k);
         check("drain_wd", WD, 100 + k);
      end
      cycle();

      // Priority collision: ALU beats the buffered entry by one cycle.
      alu_valid = 1'b1; alu_wa = 5'd2; alu_wd = 32'h5;
      mdu_valid = 1'b1; mdu_wa = 5'd7; mdu_wd = 32'h11;
      cycle();
      mdu_valid = 1'b0;
      check("prio_pend0", pend_cnt, 1);
      alu_wa = 5'd8; alu_wd = 32'h22;
      cycle();
      check("prio_wa_alu", WA, 8);
      check("prio_pend1", pend_cnt, 1);
      alu_valid = 1'b0;
      cycle();
      check("prio_wa_mdu", WA, 7);
      check("prio_wd_mdu", WD, 32'h11);
      check("prio_pend2", pend_cnt, 0);

      // Hazard query with two pending writes to the same register.
      alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h9;
      mdu_valid = 1'b1; mdu_wa = 5'd3; mdu_wd = 32'hA;
      cycle();
      mdu_wd = 32'hB;
      cycle();
      mdu_valid = 1'b0; q_ra1 = 5'd3; q_ra2 = '0;
      #1;
      check("haz_hit1", q_hit1, 1'b1);
      check("haz_hit2", q_hit2, 1'b0);
`ifdef WB_FWD_EN
      check("haz_fd1", q_fd1, 32'hB);
`endif
      cycle();
      alu_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Reset mid-drain discards buffered results.
      alu_valid = 1'b1; alu_wa = 5'd1; mdu_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mdu_wa = 5'(4 + i); mdu_wd = $urandom;
         cycle();
      end
      mdu_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_rst_pend", pend_cnt, 0);
      check("mid_rst_we", WE, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("mid_rst_quiet", WE, 1'b0);
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 49) == 0);
         alu_valid = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         alu_wa    = 5'($urandom_range(0, 7));
         alu_wd    = $urandom;
         mdu_valid = ($urandom_range(0, 2) != 0);
         mdu_wa    = 5'($urandom_range(0, 7));
         mdu_wd    = $urandom;
         q_ra1     = 5'($urandom_range(0, 7));
         q_ra2     = 5'($urandom_range(0, 7));
         cycle();
      end
      rst = 1'b0; alu_valid = 1'b0; mdu_valid = 1'b0;
      for (int i = 0; i < 6; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter driving the single register-file write port (WA/WE/WD) from two result sources.
- Sources are a single-cycle ALU path and a multi-cycle result path (MDU/load).
- The ALU path has absolute priority. Multi-cycle results are buffered in a small in-order FIFO and drained in idle ALU slots.
- Hazard-query outputs let the issue logic stall on registers whose writes are still pending.

Parameters:
- DEPTH, 4, FIFO entries for multi-cycle results; power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- alu_valid  input  1  ALU result present this cycle; always accepted, never stalled.
- alu_wa  input  AW  ALU destination register.
- alu_wd  input  DW  ALU result data.
- mdu_valid  input  1  multi-cycle result offered.
- mdu_ready  output  1  FIFO can accept; transfer occurs when mdu_valid && mdu_ready.
- mdu_wa  input  AW  multi-cycle destination register.
- mdu_wd  input  DW  multi-cycle result data.
- WE  output  1  register-file write enable (registered).
- WA  output  AW  register-file write address (registered).
- WD  output  DW  register-file write data (registered).
- q_ra1  input  AW  hazard query address 1.
- q_ra2  input  AW  hazard query address 2.
- q_hit1  output  1  a write to q_ra1 is pending (combinational).
- q_hit2  output  1  a write to q_ra2 is pending (combinational).
- q_fd1  output  DW  forwarded data for q_ra1 (see Optional Feature).
- q_fd2  output  DW  forwarded data for q_ra2 (see Optional Feature).
- pend_cnt  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - WE=0, WA=0, WD=0.
  - FIFO emptied: pointers=0, pend_cnt=0.
  - mdu_ready=0 while rst is high.
  - Reset mid-operation discards all buffered results with no write issued.
- mdu_ready = !rst && (pend_cnt != DEPTH).
  - Depends on occupancy only; there is no pop-through acceptance when full.
- FIFO push: on posedge when mdu_valid && mdu_ready.
  - mdu_wa==0: the handshake completes but nothing is stored; x0 is never written.
- Output register update, every posedge, priority order:
  1. alu_valid=1: WE<=(alu_wa!=0), WA<=alu_wa, WD<=alu_wd. The FIFO does not pop.
  2. Else FIFO not empty: WE<=1, WA/WD<=head entry; pop head.
  3. Else: WE<=0; WA and WD hold their previous values.
- Latency:
  - ALU: alu_valid in cycle N gives WE=1 in cycle N+1.
  - MDU into an empty FIFO with no ALU traffic: accepted at edge N, WE=1 in cycle N+2.
- Push and pop in the same cycle:
  - Both happen; pend_cnt is unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering:
  - FIFO entries drain strictly in acceptance order.
  - ALU results may overtake buffered entries. The issuer must use q_hit to avoid WAW/RAW hazards.
- Starvation: continuous alu_valid starves the FIFO indefinitely. Once the FIFO is full, mdu_ready stays 0 (backpressure).
- q_hitN=1 iff q_raN!=0 and either:
  - WE=1 and WA==q_raN (write lands at the next edge), or
  - any valid FIFO entry has wa==q_raN.
- q_hitN is 0 for address 0.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: q_fdN returns the youngest pending data for q_raN.
  - FIFO tail-most matching entry first; otherwise the output register if WE && WA==q_raN.
  - If q_hitN=0, q_fdN is 0.
- Not defined: q_fd1 and q_fd2 are tied to 0, and there is no match-priority logic.
- q_hit is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with mdu_valid=1 -> WE=0, WA=0, WD=0, mdu_ready=0, pend_cnt=0; nothing written after release.
- ALU path: alu_valid=1, alu_wa=5, alu_wd=0xDEADBEEF at cycle N -> WE=1, WA=5, WD=0xDEADBEEF at cycle N+1. With alu_wa=0 -> WE=0.
- MDU fill and drain: DEPTH=4, alu_valid=1 continuously, push wa=1..5 -> mdu_ready drops after 4 accepts and pend_cnt=4. Drop alu_valid -> writes wa=1,2,3,4 on consecutive cycles, then the 5th is accepted and written.
- Priority collision: FIFO holds wa=7/0x11 and alu_valid=1 wa=8/0x22 in the same cycle -> wa=8 written first, wa=7 the next cycle; pend_cnt goes 1 -> 1 -> 0.
- Hazard query: FIFO holds wa=3 and wa=3 (data 0xA then 0xB), q_ra1=3, q_ra2=0 -> q_hit1=1, q_hit2=0. With WB_FWD_EN, q_fd1=0xB.
- Reset mid-drain: 3 entries buffered, rst pulsed 1 cycle -> pend_cnt=0, WE=0, and no buffered entry is ever written.
